seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential radix-2 restoring divider. It is the inverse companion to the team's Booth multiplier.
- Operands arrive over the same shared WIDTH-bit input bus used by the multiplier: dividend first, then divisor.
- Quotient and remainder are returned one per cycle on a WIDTH-bit output bus.
- Contains its own controller FSM plus datapath (A/remainder register, Q register, divisor register, subtractor, iteration counter).
- Sits beside the multiplier in the arithmetic unit and shares its bus protocol.

Parameters:
- WIDTH, 6, operand/result width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- inBus  input  WIDTH  operand bus: dividend in the start cycle, divisor in the following cycle.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done  output  1  high while outBus carries a valid result word.
- outSel  output  1  qualifies outBus when done=1: 0 = quotient, 1 = remainder.
- divZero  output  1  divide-by-zero flag; valid with done.
- outBus  output  WIDTH  result word; driven 0 when done=0 (no tristate).

Behaviour:
- Reset: on a rst edge the FSM goes to IDLE. All registers clear. busy=0, done=0, outSel=0, divZero=0, outBus=0. rst overrides every other input, including mid-operation; a partial result is discarded and never presented.
- States and sequence, with cycle T = the cycle in which start=1 is sampled in IDLE:
  - IDLE: outputs at reset values. If start=1, dividend <= inBus at the edge ending T; go to LOADD.
  - LOADD (T+1): divisor <= inBus. A <= 0. Q <= |dividend|. Dm <= |divisor|. count <= 0. Go to CALC.
  - CALC (T+2 .. T+1+WIDTH): one iteration per cycle.
    - Shift {A,Q} left by 1.
    - Compute trial = shifted A - Dm in WIDTH+1 bits.
    - If trial has no borrow: A <= trial, Q[0] <= 1. Otherwise keep shifted A, Q[0] <= 0.
    - count increments; after exactly WIDTH iterations go to FIX.
  - FIX (T+2+WIDTH): apply sign correction.
    - Quotient is negated if the operand signs differ.
    - Remainder is negated if the dividend is negative (truncation toward zero; remainder takes the dividend's sign).
    - If divisor == 0: quotient := all ones, remainder := original dividend, divZero := 1.
  - OUTQ (T+3+WIDTH): outBus = quotient, done=1, outSel=0.
  - OUTR (T+4+WIDTH): outBus = remainder, done=1, outSel=1. Then go to IDLE.
- Latency is fixed regardless of operand values, divide-by-zero included. For WIDTH=6, the quotient appears at T+9 and the remainder at T+10.
- busy is high from T+1 through T+4+WIDTH inclusive.
- divZero is held during OUTQ and OUTR and cleared in IDLE.
- start asserted while busy=1 is ignored; it is not queued.
- start held high continuously starts a new operation on the first IDLE cycle after OUTR, i.e. back-to-back with one IDLE cycle between operations.
- inBus is ignored in every state except IDLE-with-start and LOADD.
- Arithmetic edge cases:
  - |x| is computed as an unsigned WIDTH-bit value, so the most negative number (e.g. -32) has magnitude 100000b.
  - MIN / -1 wraps: quotient = MIN (100000b for WIDTH=6), remainder = 0, divZero = 0.
  - Dividend 0 gives quotient 0 and remainder 0.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: two's-complement signed division, with sign handling and MIN/-1 wrap exactly as described in Behaviour.
- Undefined: unsigned division.
  - |x| = x.
  - FIX performs no negation.
  - Divide-by-zero still gives quotient = all ones, remainder = dividend, divZero = 1.
  - Latency and state sequence are unchanged, including the FIX cycle.

Test Plan:
- [SIGNED_DIV_EN] start with inBus=13, then inBus=4 -> at T+9 outBus=3 with done=1, outSel=0. At T+10 outBus=1 with outSel=1. divZero=0.
- [SIGNED_DIV_EN] -13/4 -> q=111101b (-3), r=111111b (-1). 13/-4 -> q=111101b, r=000001b.
- [SIGNED_DIV_EN] -32/-1 -> q=100000b, r=0, divZero=0. 0/5 -> q=0, r=0.
- 7/0 -> q=111111b, r=000111b, divZero=1 during both result cycles. Timing is identical to a normal divide.
- [no macro] 45/7 -> q=6, r=3.
- Robustness, three checks:
  - rst asserted at T+5 (mid-CALC) -> next cycle busy=0, done=0, outBus=0.
  - A fresh 13/4 then completes correctly.
  - start pulses at T+3 are ignored, and results are unchanged.

Source files
------------

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring divider, quotient then remainder on outBus
// Define SIGNED_DIV_EN for two's-complement division; otherwise operands are unsigned.
module seq_divider #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inBus,
  output logic             busy,
  output logic             done,
  output logic             outSel,
  output logic             divZero,
  output logic [WIDTH-1:0] outBus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, LOADD, CALC, FIX, OUTQ, OUTR} state_t;

  state_t           state;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regQ;
  logic [WIDTH-1:0] regDm;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             isZero;

  always_comb begin
    shifted = {regA, regQ[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, regDm};
    // A trial that would not fit back into A can only come from a borrow.
    borrow  = diff[WIDTH+1] | diff[WIDTH];
    isZero  = (divisor == '0);
`ifdef SIGNED_DIV_EN
    dividendMag = dividend[WIDTH-1] ? -dividend : dividend;
    divisorMag  = inBus[WIDTH-1] ? -inBus : inBus;
    quotient    = (dividend[WIDTH-1] ^ divisor[WIDTH-1]) ? -regQ : regQ;
    remainder   = dividend[WIDTH-1] ? -regA : regA;
`else
    dividendMag = dividend;
    divisorMag  = inBus;
    quotient    = regQ;
    remainder   = regA;
`endif
    if (isZero) begin
      quotient  = '1;
      remainder = dividend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dividend <= '0;
      divisor  <= '0;
      regA     <= '0;
      regQ     <= '0;
      regDm    <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      outSel   <= 1'b0;
      divZero  <= 1'b0;
      outBus   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend <= inBus;
            busy     <= 1'b1;
            state    <= LOADD;
          end
        end
        LOADD: begin
          divisor <= inBus;
          regA    <= '0;
          regQ    <= dividendMag;
          regDm   <= divisorMag;
          count   <= '0;
          state   <= CALC;
        end
        CALC: begin
          regA  <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          regQ  <= {regQ[WIDTH-2:0], ~borrow};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // The signed remainder is parked in A until the second result cycle.
          regA    <= remainder;
          outBus  <= quotient;
          done    <= 1'b1;
          outSel  <= 1'b0;
          divZero <= isZero;
          state   <= OUTQ;
        end
        OUTQ: begin
          outBus <= regA;
          outSel <= 1'b1;
          state  <= OUTR;
        end
        OUTR: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          outSel  <= 1'b0;
          divZero <= 1'b0;
          outBus  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
